dmx_uart_rx: RTL and testbench

DMX512 line receiver: oversamples the RS-485 receive line at 250 kbaud (8 data bits, no parity, 2 stop bits, LSB first), delivers each received slot byte, and detects the DMX break. It sits directly upstream of `dmx_rx`. It drives `dmx_rx`'s `i_Rx_DataReady`, `i_RxData` and `i_RxBreak` inputs from its `o_Rx_DataReady`, `o_RxData` and `o_RxBreak` outputs.

---
 rtl/dmx_uart_rx.sv | 184 ++++++++++++++++++
 tb/tb_dmx_uart_rx.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/dmx_uart_rx.sv
// rtl/dmx_uart_rx.sv - DMX512 UART receiver with break detection
//
// Oversampling 8N2 receiver for the DMX512 line (LSB first). It delivers each
// good slot byte, flags bad stop bits, and qualifies the DMX break.
//
// Ports:
//   i_Clock         system clock, rising edge
//   i_Reset_n       asynchronous active-low reset
//   i_RxSerial      raw receive line, idle high
//   o_Rx_DataReady  one-cycle pulse, o_RxData valid
//   o_RxData        last good byte, held until the next good byte
//   o_RxBreak       one-cycle pulse when a break is qualified
//   o_FrameError    one-cycle pulse on a bad stop bit that is not a break

module dmx_uart_rx #(
  parameter int CLKS_PER_BIT = 48,
  parameter int BREAK_BITS   = 22
) (
  input  logic       i_Clock,
  input  logic       i_Reset_n,
  input  logic       i_RxSerial,
  output logic       o_Rx_DataReady,
  output logic [7:0] o_RxData,
  output logic       o_RxBreak,
  output logic       o_FrameError
);

  localparam int               CNT_W   = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_M1  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [15:0]      BRK     = 16'(BREAK_BITS * CLKS_PER_BIT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK,
    S_WAITHIGH
  } state_t;

  state_t           state_q,   state_d;
  logic             sync1_q,   sync2_q;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q,   shift_d;
  logic [15:0]      low_cnt_q, low_cnt_d;
  logic [7:0]       data_q,    data_d;
  logic             rdy_q,     rdy_d;
  logic             brk_q,     brk_d;
  logic             ferr_q,    ferr_d;
  logic             rx_s;

  assign rx_s = sync2_q;

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      state_q   <= S_IDLE;
      bit_cnt_q <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      low_cnt_q <= '0;
      data_q    <= '0;
      rdy_q     <= 1'b0;
      brk_q     <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      sync1_q   <= i_RxSerial;
      sync2_q   <= sync1_q;
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      low_cnt_q <= low_cnt_d;
      data_q    <= data_d;
      rdy_q     <= rdy_d;
      brk_q     <= brk_d;
      ferr_q    <= ferr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    data_d    = data_q;
    rdy_d     = 1'b0;
    brk_d     = 1'b0;
    ferr_d    = 1'b0;

    // Low-time counter runs in every state; saturates so a stuck-low line
    // can never wrap back under the break threshold.
    if (rx_s) begin
      low_cnt_d = '0;
    end else if (low_cnt_q == 16'hFFFF) begin
      low_cnt_d = low_cnt_q;
    end else begin
      low_cnt_d = low_cnt_q + 16'd1;
    end

    case (state_q)
      S_IDLE: begin
        bit_cnt_d = '0;
        if (!rx_s) begin
          state_d = S_START;
        end
      end

      S_START: begin
        if (bit_cnt_q == HALF_M1) begin
          bit_cnt_d = '0;
          bit_idx_d = '0;
          // High at mid start bit means the low was only a glitch.
          state_d   = rx_s ? S_IDLE : S_DATA;
        end else begin
          bit_cnt_d = bit_cnt_q + CNT_ONE;
        end
      end

      S_DATA: begin
        if (bit_cnt_q == BIT_M1) begin
          bit_cnt_d          = '0;
          shift_d[bit_idx_q] = rx_s;
          if (bit_idx_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + CNT_ONE;
        end
      end

      S_STOP: begin
        if (bit_cnt_q == BIT_M1) begin
          bit_cnt_d = '0;
          if (rx_s) begin
            data_d  = shift_q;
            rdy_d   = 1'b1;
            state_d = S_IDLE;
          end else if (shift_q != 8'h00) begin
            ferr_d  = 1'b1;
            state_d = S_WAITHIGH;
          end else begin
            // All-zero byte with low stop: possibly a break, decided later.
            state_d = S_BREAK;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + CNT_ONE;
        end
      end

      S_BREAK: begin
        if (rx_s) begin
          ferr_d  = 1'b1;
          state_d = S_IDLE;
        end else if (low_cnt_q >= BRK) begin
          brk_d   = 1'b1;
          state_d = S_WAITHIGH;
        end
      end

      S_WAITHIGH: begin
        if (rx_s) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign o_Rx_DataReady = rdy_q;
  assign o_RxData       = data_q;
  assign o_RxBreak      = brk_q;
  assign o_FrameError   = ferr_q;

endmodule

// File: tb/tb_dmx_uart_rx.sv
// tb/tb_dmx_uart_rx.sv - directed self-checking bench for dmx_uart_rx

module tb_dmx_uart_rx;

  localparam int CPB = 48;

  logic       clk;
  logic       rst_n;
  logic       rx;
  logic       rdy;
  logic [7:0] data;
  logic       brk;
  logic       ferr;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  int rdy_cnt  = 0;
  int brk_cnt  = 0;
  int ferr_cnt = 0;
  int rdy_cyc  = 0;
  int prev_rdy_cyc = 0;
  int brk_cyc  = 0;
  int fall_cyc = 0;

  int r0, b0, f0, p0;

  dmx_uart_rx #(
    .CLKS_PER_BIT(CPB),
    .BREAK_BITS  (22)
  ) dut (
    .i_Clock       (clk),
    .i_Reset_n     (rst_n),
    .i_RxSerial    (rx),
    .o_Rx_DataReady(rdy),
    .o_RxData      (data),
    .o_RxBreak     (brk),
    .o_FrameError  (ferr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rdy) begin
      rdy_cnt++;
      prev_rdy_cyc = rdy_cyc;
      rdy_cyc      = cyc;
    end
    if (brk) begin
      brk_cnt++;
      brk_cyc = cyc;
    end
    if (ferr) ferr_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic hold(input logic v, input int n);
    rx = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_ok);
    fall_cyc = cyc;
    hold(1'b0, CPB);
    for (int i = 0; i < 8; i++) hold(b[i], CPB);
    if (stop_ok) hold(1'b1, 2 * CPB);
    else         hold(1'b0, CPB);
  endtask

  task automatic snap();
    r0 = rdy_cnt;
    b0 = brk_cnt;
    f0 = ferr_cnt;
  endtask

  initial begin
    rst_n = 1'b0;
    rx    = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_rdy",  {31'd0, rdy},  32'd0);
    chk("reset_data", {24'd0, data}, 32'd0);
    chk("reset_brk",  {31'd0, brk},  32'd0);
    chk("reset_ferr", {31'd0, ferr}, 32'd0);
    rst_n = 1'b1;

    // Idle line
    snap();
    hold(1'b1, 1000);
    chk("idle_pulses", rdy_cnt + brk_cnt + ferr_cnt - r0 - b0 - f0, 32'd0);

    // 0xA5 with latency
    snap();
    send_byte(8'hA5, 1'b1);
    chk("a5_count",   rdy_cnt - r0, 32'd1);
    chk("a5_latency", rdy_cyc - fall_cyc, 32'd459);
    chk("a5_data",    {24'd0, data}, 32'h0A5);
    chk("a5_noerr",   brk_cnt + ferr_cnt - b0 - f0, 32'd0);

    // Break, mark, start code 0x00, slot 0xFF
    snap();
    fall_cyc = cyc;
    p0 = fall_cyc;
    hold(1'b0, 1104);
    chk("brk_count",   brk_cnt - b0, 32'd1);
    chk("brk_latency", brk_cyc - p0, 32'd1059);
    hold(1'b1, 144);
    send_byte(8'h00, 1'b1);
    chk("sc_count", rdy_cnt - r0, 32'd1);
    chk("sc_data",  {24'd0, data}, 32'h000);
    send_byte(8'hFF, 1'b1);
    chk("slot_count", rdy_cnt - r0, 32'd2);
    chk("slot_data",  {24'd0, data}, 32'h0FF);
    chk("slot_gap",   rdy_cyc - prev_rdy_cyc, 32'd528);
    chk("brk_seq_noferr", ferr_cnt - f0, 32'd0);
    chk("brk_seq_once",   brk_cnt - b0, 32'd1);

    // Bad stop bit on 0x3C, then 0x11
    snap();
    send_byte(8'h3C, 1'b0);
    hold(1'b1, 200);
    chk("fe_count",  ferr_cnt - f0, 32'd1);
    chk("fe_nordy",  rdy_cnt - r0, 32'd0);
    chk("fe_nobrk",  brk_cnt - b0, 32'd0);
    chk("fe_hold",   {24'd0, data}, 32'h0FF);
    send_byte(8'h11, 1'b1);
    chk("after_fe_count", rdy_cnt - r0, 32'd1);
    chk("after_fe_data",  {24'd0, data}, 32'h011);

    // 20-clock glitch
    snap();
    hold(1'b0, 20);
    hold(1'b1, 200);
    chk("glitch_pulses", rdy_cnt + brk_cnt + ferr_cnt - r0 - b0 - f0, 32'd0);

    // Short low: zero byte with low stop, too short for a break
    snap();
    hold(1'b0, 480);
    hold(1'b1, 200);
    chk("short_ferr", ferr_cnt - f0, 32'd1);
    chk("short_nobrk", brk_cnt - b0, 32'd0);
    chk("short_nordy", rdy_cnt - r0, 32'd0);
    chk("short_hold", {24'd0, data}, 32'h011);

    // Reset mid-byte (bit 4 of 0x5A), then 0x81
    snap();
    hold(1'b0, CPB);
    hold(1'b0, CPB);
    hold(1'b1, CPB);
    hold(1'b0, CPB);
    hold(1'b1, CPB);
    hold(1'b1, CPB / 2);
    rst_n = 1'b0;
    #1;
    chk("midrst_data", {24'd0, data}, 32'd0);
    chk("midrst_outs", {29'd0, rdy, brk, ferr}, 32'd0);
    hold(1'b1, 3);
    rst_n = 1'b1;
    hold(1'b1, 600);
    chk("midrst_quiet", rdy_cnt + brk_cnt + ferr_cnt - r0 - b0 - f0, 32'd0);
    send_byte(8'h81, 1'b1);
    chk("post_rst_count", rdy_cnt - r0, 32'd1);
    chk("post_rst_data",  {24'd0, data}, 32'h081);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
